// File: rtl/step_pulser.sv
// Button conditioning for the mod-6 display counter: two-flop synchronisers,
// per-button debounce/auto-repeat, and an up-priority step/direction register.

module step_pulser_chan #(
    parameter int unsigned DEB_CYCLES    = 16,
    parameter int unsigned REPEAT_CYCLES = 0,
    parameter int unsigned CNT_W         = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic s,
    output logic lvl,
    output logic ev
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST =
        CNT_W'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);
    localparam logic REP_EN = (REPEAT_CYCLES > 0);

    state_t           st, st_nx;
    logic [CNT_W-1:0] deb_cnt, deb_nx;
    logic [CNT_W-1:0] rep_cnt, rep_nx;
    logic             lvl_nx;
    logic             accept;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            st      <= IDLE;
            lvl     <= 1'b0;
            deb_cnt <= '0;
            rep_cnt <= '0;
        end else begin
            st      <= st_nx;
            lvl     <= lvl_nx;
            deb_cnt <= deb_nx;
            rep_cnt <= rep_nx;
        end
    end

    always_comb begin
        accept = (s != lvl) && (deb_cnt == DEB_LAST);
        lvl_nx = lvl;
        deb_nx = '0;
        st_nx  = st;
        rep_nx = rep_cnt;
        ev     = 1'b0;

        if (accept) begin
            lvl_nx = s;
        end else if (s != lvl) begin
            deb_nx = deb_cnt + 1'b1;
        end

        // an accepted release outranks a repeat landing on the same edge
        case (st)
            IDLE: begin
                if (accept) begin
                    st_nx  = HELD;
                    ev     = 1'b1;
                    rep_nx = '0;
                end
            end
            HELD, REPEAT: begin
                if (accept) begin
                    st_nx  = IDLE;
                    rep_nx = '0;
                end else if (REP_EN) begin
                    if (rep_cnt == REP_LAST) begin
                        st_nx  = REPEAT;
                        ev     = 1'b1;
                        rep_nx = '0;
                    end else begin
                        rep_nx = rep_cnt + 1'b1;
                    end
                end
            end
            default: st_nx = IDLE;
        endcase
    end

endmodule

module step_pulser #(
    parameter int unsigned DEB_CYCLES    = 16,
    parameter int unsigned REPEAT_CYCLES = 0,
    parameter int unsigned CNT_W         = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_up,
    input  logic btn_dn,
    output logic step,
    output logic u,
    output logic up_lvl,
    output logic dn_lvl
);

    logic meta_up, meta_dn;
    logic s_up, s_dn;
    logic ev_up, ev_dn;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            meta_up <= 1'b0;
            meta_dn <= 1'b0;
            s_up    <= 1'b0;
            s_dn    <= 1'b0;
        end else begin
            meta_up <= btn_up;
            meta_dn <= btn_dn;
            s_up    <= meta_up;
            s_dn    <= meta_dn;
        end
    end

    step_pulser_chan #(
        .DEB_CYCLES    (DEB_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_chan_up (
        .clk (clk),
        .clr (clr),
        .s   (s_up),
        .lvl (up_lvl),
        .ev  (ev_up)
    );

    step_pulser_chan #(
        .DEB_CYCLES    (DEB_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_chan_dn (
        .clk (clk),
        .clr (clr),
        .s   (s_dn),
        .lvl (dn_lvl),
        .ev  (ev_dn)
    );

    // simultaneous events collapse to one up step; the down event is dropped
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            step <= 1'b0;
            u    <= 1'b1;
        end else begin
            step <= ev_up | ev_dn;
            if (ev_up) begin
                u <= 1'b1;
            end else if (ev_dn) begin
                u <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_step_pulser.sv
// Randomised and directed bench for step_pulser: two instances (no repeat /
// repeat every 8) checked each cycle against a window-based reference model.

module tb_step_pulser;

    localparam int DEB  = 4;
    localparam int REP0 = 0;
    localparam int REP1 = 8;

    logic       clk    = 1'b0;
    logic       clr    = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_dn = 1'b0;
    logic [1:0] d_step, d_u, d_ul, d_dl;

    step_pulser #(
        .DEB_CYCLES    (DEB),
        .REPEAT_CYCLES (REP0),
        .CNT_W         (8)
    ) dut0 (
        .clk    (clk),
        .clr    (clr),
        .btn_up (btn_up),
        .btn_dn (btn_dn),
        .step   (d_step[0]),
        .u      (d_u[0]),
        .up_lvl (d_ul[0]),
        .dn_lvl (d_dl[0])
    );

    step_pulser #(
        .DEB_CYCLES    (DEB),
        .REPEAT_CYCLES (REP1),
        .CNT_W         (8)
    ) dut1 (
        .clk    (clk),
        .clr    (clr),
        .btn_up (btn_up),
        .btn_dn (btn_dn),
        .step   (d_step[1]),
        .u      (d_u[1]),
        .up_lvl (d_ul[1]),
        .dn_lvl (d_dl[1])
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // raw button samples taken at each clock edge since the last reset
    int raw_up[$];
    int raw_dn[$];

    int m_lvl[2];
    int m_held[2][2];
    int m_step[2];
    int m_u[2];
    int nup[2];
    int ndn[2];
    int dut_cnt[2];
    int rep_of[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // debouncer input at edge e is the raw sample two edges earlier
    function automatic int deb_in(int ch, int e);
        int idx;
        idx = e - 3;
        if (idx < 0) return 0;
        return (ch == 0) ? raw_up[idx] : raw_dn[idx];
    endfunction

    function automatic bit window_differs(int ch, int lvl);
        int e;
        e = raw_up.size();
        for (int j = 0; j < DEB; j++) begin
            if (deb_in(ch, e - j) == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        raw_up.delete();
        raw_dn.delete();
        for (int i = 0; i < 2; i++) begin
            m_lvl[i]  = 0;
            m_step[i] = 0;
            m_u[i]    = 1;
            for (int ch = 0; ch < 2; ch++) m_held[i][ch] = 0;
        end
    endtask

    task automatic model_edge();
        bit flip[2];
        bit ev[2][2];
        raw_up.push_back(int'(btn_up));
        raw_dn.push_back(int'(btn_dn));
        for (int ch = 0; ch < 2; ch++) flip[ch] = window_differs(ch, m_lvl[ch]);
        for (int i = 0; i < 2; i++) begin
            for (int ch = 0; ch < 2; ch++) begin
                ev[i][ch] = 1'b0;
                if (flip[ch]) begin
                    if (m_lvl[ch] == 0) begin
                        ev[i][ch]    = 1'b1;
                        m_held[i][ch] = 0;
                    end
                end else if (m_lvl[ch] == 1) begin
                    m_held[i][ch]++;
                    if (rep_of[i] > 0 && (m_held[i][ch] % rep_of[i]) == 0) ev[i][ch] = 1'b1;
                end
            end
        end
        for (int ch = 0; ch < 2; ch++) if (flip[ch]) m_lvl[ch] = 1 - m_lvl[ch];
        for (int i = 0; i < 2; i++) begin
            m_step[i] = (ev[i][0] || ev[i][1]) ? 1 : 0;
            if (ev[i][0]) begin
                m_u[i] = 1;
                nup[i]++;
            end else if (ev[i][1]) begin
                m_u[i] = 0;
                ndn[i]++;
            end
        end
    endtask

    task automatic compare_all();
        int ref_cnt;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("dut%0d step", i),   32'(d_step[i]), m_step[i]);
            check($sformatf("dut%0d u", i),      32'(d_u[i]),    m_u[i]);
            check($sformatf("dut%0d up_lvl", i), 32'(d_ul[i]),   m_lvl[0]);
            check($sformatf("dut%0d dn_lvl", i), 32'(d_dl[i]),   m_lvl[1]);
            ref_cnt = (((nup[i] - ndn[i]) % 6) + 6) % 6;
            check($sformatf("dut%0d count", i),  dut_cnt[i],     ref_cnt);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!clr) model_edge();
        for (int i = 0; i < 2; i++) begin
            if (d_step[i] === 1'b1) begin
                dut_cnt[i] = (d_u[i] === 1'b1) ? (dut_cnt[i] + 1) % 6 : (dut_cnt[i] + 5) % 6;
            end
        end
        compare_all();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_reset(input int cycles);
        clr = 1'b1;
        model_reset();
        #1;
        compare_all();
        repeat (cycles) tick();
        clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int bpat[6];
        int rem[2];
        bpat = '{1, 0, 1, 1, 0, 1};
        rep_of[0] = REP0;
        rep_of[1] = REP1;
        for (int i = 0; i < 2; i++) begin
            nup[i]     = 0;
            ndn[i]     = 0;
            dut_cnt[i] = 0;
        end

        #2;
        pulse_reset(2);
        ticks(3);

        // press and release up
        btn_up = 1'b1;
        ticks(12);
        btn_up = 1'b0;
        ticks(12);

        // bouncing down press
        for (int k = 0; k < 6; k++) begin
            btn_dn = bpat[k][0];
            tick();
        end
        btn_dn = 1'b1;
        ticks(12);
        btn_dn = 1'b0;
        ticks(12);

        // simultaneous press
        btn_up = 1'b1;
        btn_dn = 1'b1;
        ticks(16);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        ticks(12);

        // long down hold
        btn_dn = 1'b1;
        ticks(40);
        btn_dn = 1'b0;
        ticks(16);

        // reset mid-debounce, then mid-repeat, with up still held
        btn_up = 1'b1;
        ticks(5);
        pulse_reset(1);
        ticks(20);
        pulse_reset(1);
        ticks(12);
        btn_up = 1'b0;
        ticks(12);

        // down pressed while up held and repeating
        btn_up = 1'b1;
        ticks(12);
        btn_dn = 1'b1;
        ticks(30);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        ticks(12);

        // random activity with short bounces and long holds
        rem = '{1, 1};
        for (int c = 0; c < 1500; c++) begin
            for (int ch = 0; ch < 2; ch++) begin
                rem[ch]--;
                if (rem[ch] <= 0) begin
                    if (ch == 0) btn_up = ~btn_up;
                    else         btn_dn = ~btn_dn;
                    rem[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5))
                                                          : int'($urandom_range(6, 50));
                end
            end
            if ($urandom_range(0, 599) == 0) pulse_reset(1);
            else tick();
        end
        btn_up = 1'b0;
        btn_dn = 1'b0;
        ticks(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
